// File: rtl/aes256_cp_host_driver_if.sv
// aes256_cp_host_driver_if: host request/result handshake plus coprocessor register-port signals
interface aes256_cp_host_driver_if;
   logic         start;
   logic         key_load;
   logic [255:0] key;
   logic [127:0] nonce;
   logic [127:0] block_in;
   logic         ready;
   logic         done;
   logic         error;
   logic [127:0] block_out;
   logic [3:0]   cp_addr;
   logic [31:0]  cp_wdata;
   logic         cp_write_en;
   logic [31:0]  cp_rdata;
   logic         cp_interrupt;
   modport master (
      input  start, key_load, key, nonce, block_in, cp_rdata, cp_interrupt,
      output ready, done, error, block_out, cp_addr, cp_wdata, cp_write_en
   );
   modport slave (
      output start, key_load, key, nonce, block_in, cp_rdata, cp_interrupt,
      input  ready, done, error, block_out, cp_addr, cp_wdata, cp_write_en
   );
endinterface

// File: rtl/aes256_cp_host_driver.sv
// aes256_cp_host_driver: sequences nonce/key/data writes, run, wait and readback on an aes256 coprocessor port
module aes256_cp_host_driver #(
   parameter int TIMEOUT = 1024,
   parameter int TW      = 11
) (
   input logic                     clock,
   input logic                     rst,
   aes256_cp_host_driver_if.master bus
);
   // the index must reach 7 for the key words even when the timeout is tiny
   localparam int CW = (TW > 3) ? TW : 3;
   typedef enum logic [2:0] {IDLE, LD_NONCE, LD_KEY, LD_DATA, RUN, WAIT, READ, ABORT} state_t;
   state_t        st_q, st_d;
   logic [CW-1:0] idx_q, idx_d;
   logic [255:0]  key_q, key_d;
   logic [127:0]  nonce_q, nonce_d, blk_q, blk_d, rd_q, rd_d, out_q, out_d;
   logic          done_q, done_d, err_q, err_d, we_q, we_d;
   logic [3:0]    addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;

   // next state; one counter is the write index and the WAIT timeout count, cleared on every entry
   always_comb begin
      st_d    = st_q;
      idx_d   = idx_q + 1'b1;
      key_d   = key_q;
      nonce_d = nonce_q;
      blk_d   = blk_q;
      rd_d    = rd_q;
      out_d   = out_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (st_q)
         IDLE: begin
            idx_d = '0;
            if (bus.start) begin
               key_d   = bus.key;
               nonce_d = bus.nonce;
               blk_d   = bus.block_in;
               st_d    = bus.key_load ? LD_NONCE : LD_DATA;
            end
         end
         LD_NONCE: if (idx_q == CW'(3)) begin st_d = LD_KEY; idx_d = '0; end
         LD_KEY:   if (idx_q == CW'(7)) begin st_d = LD_DATA; idx_d = '0; end
         LD_DATA:  if (idx_q == CW'(3)) begin st_d = RUN; idx_d = '0; end
         RUN:      begin st_d = WAIT; idx_d = '0; end
         // interrupt is a level that may still be high from the previous op, so skip the first cycle
         WAIT: begin
            if (idx_q != '0 && bus.cp_interrupt) begin
               st_d  = READ;
               idx_d = '0;
            end else if (idx_q == CW'(TIMEOUT - 1)) begin
               st_d  = ABORT;
               idx_d = '0;
            end
         end
         READ: begin
            rd_d[32*idx_q[1:0] +: 32] = bus.cp_rdata;
            if (idx_q == CW'(3)) begin
               out_d  = {bus.cp_rdata, rd_q[95:0]};
               done_d = 1'b1;
               st_d   = IDLE;
               idx_d  = '0;
            end
         end
         ABORT: begin
            st_d   = IDLE;
            idx_d  = '0;
            done_d = 1'b1;
            err_d  = 1'b1;
         end
         default: begin
            st_d  = IDLE;
            idx_d = '0;
         end
      endcase
   end

   // register-port values for the cycle the FSM is about to enter, so cp_* come straight from flops
   always_comb begin
      addr_d  = 4'd0;
      wdata_d = 32'd0;
      we_d    = 1'b0;
      case (st_d)
         LD_NONCE: begin addr_d = 4'd1 + 4'(idx_d[1:0]); wdata_d = nonce_d[32*idx_d[1:0] +: 32]; we_d = 1'b1; end
         LD_KEY:   begin addr_d = 4'd5 + 4'(idx_d[2:0]); wdata_d = key_d[32*idx_d[2:0] +: 32]; we_d = 1'b1; end
         LD_DATA:  begin addr_d = 4'd13; wdata_d = blk_d[32*idx_d[1:0] +: 32]; we_d = 1'b1; end
         RUN:      begin wdata_d = 32'h0000_0001; we_d = 1'b1; end
         WAIT:     addr_d = 4'd14;
         READ:     addr_d = 4'd14;
         ABORT:    begin wdata_d = 32'h0000_0002; we_d = 1'b1; end
         default:  addr_d = 4'd0;
      endcase
   end

   // state and output registers; async reset drops any write in flight immediately
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         st_q    <= IDLE;
         idx_q   <= '0;
         key_q   <= '0;
         nonce_q <= '0;
         blk_q   <= '0;
         rd_q    <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= 4'd0;
         wdata_q <= 32'd0;
         we_q    <= 1'b0;
      end else begin
         st_q    <= st_d;
         idx_q   <= idx_d;
         key_q   <= key_d;
         nonce_q <= nonce_d;
         blk_q   <= blk_d;
         rd_q    <= rd_d;
         out_q   <= out_d;
         done_q  <= done_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
      end
   end

   assign bus.ready       = (st_q == IDLE);
   assign bus.done        = done_q;
   assign bus.error       = err_q;
   assign bus.block_out   = out_q;
   assign bus.cp_addr     = addr_q;
   assign bus.cp_wdata    = wdata_q;
   assign bus.cp_write_en = we_q;
endmodule
